epoch_alarm: RTL and testbench
==============================

Name: epoch_alarm

Overview:
Downstream consumer of the 64-bit epoch timer output. Holds a programmable alarm time and optional repeat period, compares them against the running epoch every clock, and raises a sticky interrupt plus a stretched pin pulse on match. Alarm registers are loaded from the SPI command FSM, and the interrupt is acknowledged through the same path. It sits beside the timer in the top level, fed by the timer's time output and the spi_fsm buffer interface.

Parameters:
TIME_WIDTH, 64, width of epoch and alarm time
PERIOD_WIDTH, 32, width of repeat period (zero-extended for addition)
PULSE_CYCLES, 16, clk cycles o_pulse stays high per fire (>=1)
COUNT_WIDTH, 8, width of saturating fire counter

Ports:
clk  in  1  system clock (internal oscillator domain)
rst_n  in  1  asynchronous, active-low reset
i_time  in  TIME_WIDTH  current epoch from the timer, synchronous to clk
load  in  1  single-cycle strobe: capture i_alarm/i_period and arm
i_alarm  in  TIME_WIDTH  alarm time to load
i_period  in  PERIOD_WIDTH  repeat period; 0 = one-shot
disarm  in  1  single-cycle strobe: stop matching
ack  in  1  single-cycle strobe: clear o_irq and fire count
o_irq  out  1  sticky interrupt, held until ack
o_pulse  out  1  stretched pulse for an external pin
o_armed  out  1  high in state ARMED
o_alarm_time  out  TIME_WIDTH  current alarm register (readback)
o_fire_count  out  COUNT_WIDTH  fires since last ack, saturating

Behaviour:
- Reset (async, rst_n low): state IDLE, alarm_reg=0, period_reg=0, o_irq=0, o_pulse=0, pulse counter=0, o_fire_count=0, o_armed=0. Outputs return to these values immediately on reset, including mid-fire or mid-pulse.
- States: IDLE, ARMED. o_irq is a separate sticky flag, independent of state.
- fire = (state==ARMED) && (i_time >= alarm_reg), unsigned and combinational in cycle N. Registered effects appear at N+1.
- On fire at cycle N:
  - o_irq=1 at N+1.
  - o_fire_count increments at N+1 and saturates at 2^COUNT_WIDTH-1.
  - Pulse counter loads PULSE_CYCLES, so o_pulse is high for exactly PULSE_CYCLES cycles starting N+1. A retrigger during a pulse reloads the counter.
  - If period_reg != 0: alarm_reg <= alarm_reg + period_reg (truncated to TIME_WIDTH, wraps modulo 2^TIME_WIDTH) and the block stays ARMED.
  - If period_reg == 0: go to IDLE.
- Catch-up: if alarm_reg+period is still <= i_time (epoch jumped forward via a timer load), fire repeats on consecutive cycles until caught up. Each repeat counts.
- load at N: alarm_reg=i_alarm, period_reg=i_period, state=ARMED at N+1. The first compare against the new alarm occurs at N+1. Loading a time already <= i_time fires at N+1 (visible N+2). load does not clear o_irq.
- disarm at N: state=IDLE at N+1. No fire is evaluated in cycle N. If load and disarm arrive in the same cycle, disarm wins, but alarm_reg and period_reg are still updated.
- ack at N: o_irq=0 and o_fire_count=0 at N+1. o_pulse is unaffected.
- ack and fire in the same cycle: fire wins, giving o_irq=1 and o_fire_count=1.
- Epoch behaviour: i_time wrap or rollback is not special-cased. The >= compare simply stops firing until time reaches alarm_reg.
- one_hz is not used; the block works purely from i_time changes.

Decomposition:
- Shared package/header holds:
  - TIME_WIDTH default
  - state encodings (ST_IDLE=1'b0, ST_ARMED=1'b1)
  - SPI command codes for alarm write, read and ack, alongside the existing WRCMD/RDCMD
- One natural sub-module: pulse_stretch (load/retrigger down-counter producing o_pulse), reusable for the divider debug output.

Test Plan:
1. Reset then load i_alarm=100, i_period=0, with i_time ramping 98,99,100,101 -> fire seen at i_time=100, o_irq=1 next cycle, o_pulse high 16 cycles, o_armed=0, o_fire_count=1. No second fire at 101.
2. Periodic: load alarm=10, period=5, i_time stepping 10..25 -> fires at 10,15,20,25; o_alarm_time ends at 30; o_fire_count=4; o_irq stays 1 with no ack.
3. Catch-up: alarm=10, period=5, i_time jumps 0->22 -> three consecutive-cycle fires (10,15,20), alarm_reg=25, o_fire_count=3, o_pulse stays high 16 cycles after the last fire.
4. Simultaneous ack and fire at the alarm cycle -> o_irq remains 1, o_fire_count=1. A lone ack next cycle -> o_irq=0, count=0.
5. Load and disarm in the same cycle with alarm=5 and i_time=50 -> o_armed=0, o_alarm_time=5, no irq.
6. Assert rst_n low mid-pulse (cycle 7 of 16) while armed -> all outputs 0 immediately without a clock edge. After release the block stays IDLE and does not fire.

Source files
------------

// File: rtl/epoch_alarm_pkg.sv
// +------------------------------------------------------------------+
// | epoch_alarm_pkg : shared types and command codes for epoch_alarm |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package epoch_alarm_pkg;

  localparam int TIME_WIDTH_DEFAULT = 64;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

  // SPI command byte codes decoded by the spi_fsm
  localparam logic [7:0] WRCMD        = 8'h02;
  localparam logic [7:0] RDCMD        = 8'h03;
  localparam logic [7:0] ALARM_WRCMD  = 8'h20;
  localparam logic [7:0] ALARM_RDCMD  = 8'h21;
  localparam logic [7:0] ALARM_ACKCMD = 8'h22;

endpackage

`default_nettype wire

// File: rtl/epoch_alarm_pulse_stretch.sv
// +------------------------------------------------------------------+
// | pulse_stretch : retriggerable down-counter, output high for      |
// | PULSE_CYCLES cycles after the last trigger. Revision: 1.0        |
// +------------------------------------------------------------------+
`default_nettype none

module pulse_stretch #(
  parameter int PULSE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trigger,
  output logic o_pulse
);

  localparam int CNT_W = $clog2(PULSE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PULSE_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (trigger) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_pulse = (cnt_q != '0);

endmodule

`default_nettype wire

// File: rtl/epoch_alarm.sv
// +------------------------------------------------------------------+
// | epoch_alarm : programmable one-shot/periodic alarm on the epoch, |
// | sticky irq, saturating fire count, stretched pin pulse. Rev 1.0  |
// +------------------------------------------------------------------+
`default_nettype none

module epoch_alarm
  import epoch_alarm_pkg::*;
#(
  parameter int TIME_WIDTH   = TIME_WIDTH_DEFAULT,
  parameter int PERIOD_WIDTH = 32,
  parameter int PULSE_CYCLES = 16,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [TIME_WIDTH-1:0]   i_time,
  input  logic                    load,
  input  logic [TIME_WIDTH-1:0]   i_alarm,
  input  logic [PERIOD_WIDTH-1:0] i_period,
  input  logic                    disarm,
  input  logic                    ack,
  output logic                    o_irq,
  output logic                    o_pulse,
  output logic                    o_armed,
  output logic [TIME_WIDTH-1:0]   o_alarm_time,
  output logic [COUNT_WIDTH-1:0]  o_fire_count
);

  state_e                  state_q,  state_d;
  logic [TIME_WIDTH-1:0]   alarm_q,  alarm_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic                    irq_q,    irq_d;
  logic [COUNT_WIDTH-1:0]  count_q,  count_d;
  logic                    fire;

  // A disarm in the same cycle suppresses evaluation entirely.
  assign fire = (state_q == ST_ARMED) && !disarm && (i_time >= alarm_q);

  always_comb begin
    state_d  = state_q;
    alarm_d  = alarm_q;
    period_d = period_q;
    irq_d    = irq_q;
    count_d  = count_q;

    if (fire) begin
      irq_d = 1'b1;
      if (ack) begin
        count_d = COUNT_WIDTH'(1);
      end else if (count_q != '1) begin
        count_d = count_q + COUNT_WIDTH'(1);
      end
      if (period_q != '0) begin
        alarm_d = alarm_q + TIME_WIDTH'(period_q);
      end else begin
        state_d = ST_IDLE;
      end
    end else if (ack) begin
      irq_d   = 1'b0;
      count_d = '0;
    end

    // Load overrides any periodic advance; disarm overrides the arm.
    if (load) begin
      alarm_d  = i_alarm;
      period_d = i_period;
      state_d  = ST_ARMED;
    end
    if (disarm) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      alarm_q  <= '0;
      period_q <= '0;
      irq_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      alarm_q  <= alarm_d;
      period_q <= period_d;
      irq_q    <= irq_d;
      count_q  <= count_d;
    end
  end

  pulse_stretch #(
    .PULSE_CYCLES(PULSE_CYCLES)
  ) u_pulse (
    .clk    (clk),
    .rst_n  (rst_n),
    .trigger(fire),
    .o_pulse(o_pulse)
  );

  assign o_irq        = irq_q;
  assign o_armed      = (state_q == ST_ARMED);
  assign o_alarm_time = alarm_q;
  assign o_fire_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_epoch_alarm.sv
// +------------------------------------------------------------------+
// | tb_epoch_alarm : scoreboard bench with a behavioural alarm model |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_epoch_alarm;

  localparam int PULSE = 16;

  typedef struct {
    logic        irq;
    logic        pulse;
    logic        armed;
    logic [63:0] alarm;
    logic [7:0]  count;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] i_time = '0;
  logic        load = 1'b0;
  logic [63:0] i_alarm = '0;
  logic [31:0] i_period = '0;
  logic        disarm = 1'b0;
  logic        ack = 1'b0;
  logic        o_irq, o_pulse, o_armed;
  logic [63:0] o_alarm_time;
  logic [7:0]  o_fire_count;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];

  // Reference model state
  bit              m_armed;
  longint unsigned m_alarm;
  longint unsigned m_period;
  bit              m_irq;
  int              m_count;
  int              m_pulse_left;

  epoch_alarm dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_time      (i_time),
    .load        (load),
    .i_alarm     (i_alarm),
    .i_period    (i_period),
    .disarm      (disarm),
    .ack         (ack),
    .o_irq       (o_irq),
    .o_pulse     (o_pulse),
    .o_armed     (o_armed),
    .o_alarm_time(o_alarm_time),
    .o_fire_count(o_fire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_alarm = 0; m_period = 0;
    m_irq = 0; m_count = 0; m_pulse_left = 0;
  endtask

  // Monitor: outputs are presented every cycle, so drain the scoreboard at each negedge.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk("irq",        64'(o_irq),        64'(e.irq));
      chk("pulse",      64'(o_pulse),      64'(e.pulse));
      chk("armed",      64'(o_armed),      64'(e.armed));
      chk("alarm_time", o_alarm_time,      e.alarm);
      chk("fire_count", 64'(o_fire_count), 64'(e.count));
    end
  end

  // One clock cycle of stimulus; the model predicts the state after the edge.
  task automatic step(input logic [63:0] t, input bit ld, input logic [63:0] al,
                      input logic [31:0] per, input bit dis, input bit ak);
    bit   fire;
    exp_t e;
    i_time = t; load = ld; i_alarm = al; i_period = per; disarm = dis; ack = ak;
    fire = m_armed && !dis && (t >= m_alarm);
    if (fire) begin
      m_irq = 1;
      m_count = ak ? 1 : ((m_count < 255) ? m_count + 1 : 255);
      m_pulse_left = PULSE;
      if (m_period != 0) m_alarm = m_alarm + m_period;
      else m_armed = 0;
    end else begin
      if (ak) begin m_irq = 0; m_count = 0; end
      if (m_pulse_left > 0) m_pulse_left--;
    end
    if (ld) begin m_alarm = al; m_period = 64'(per); m_armed = 1; end
    if (dis) m_armed = 0;
    @(posedge clk);
    e.irq = m_irq; e.pulse = (m_pulse_left > 0); e.armed = m_armed;
    e.alarm = m_alarm; e.count = 8'(m_count);
    sb.push_back(e);
    #1;
    load = 0; disarm = 0; ack = 0;
  endtask

  task automatic idle(input logic [63:0] t, input int n);
    for (int k = 0; k < n; k++) step(t, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, "_irq"},   64'(o_irq),        64'd0);
    chk({tag, "_pulse"}, 64'(o_pulse),      64'd0);
    chk({tag, "_armed"}, 64'(o_armed),      64'd0);
    chk({tag, "_alarm"}, o_alarm_time,      64'd0);
    chk({tag, "_count"}, 64'(o_fire_count), 64'd0);
  endtask

  initial begin
    logic [63:0] t;
    model_reset();
    #3;
    check_reset_zero("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // One-shot alarm at 100 with a time ramp
    step(98, 1, 100, 0, 0, 0);
    step(99, 0, 0, 0, 0, 0);
    step(100, 0, 0, 0, 0, 0);
    idle(101, 20);

    // Periodic alarm stepping through four periods
    step(101, 0, 0, 0, 0, 1);
    step(9, 1, 10, 5, 0, 0);
    for (int k = 10; k <= 25; k++) step(64'(k), 0, 0, 0, 0, 0);
    idle(25, 3);

    // Catch-up after a forward jump
    step(25, 0, 0, 0, 1, 1);
    step(0, 1, 10, 5, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    idle(22, 20);

    // Simultaneous ack and fire, then a lone ack
    step(22, 0, 0, 0, 1, 1);
    step(30, 1, 40, 0, 0, 0);
    step(35, 0, 0, 0, 0, 0);
    step(40, 0, 0, 0, 0, 1);
    step(40, 0, 0, 0, 0, 1);
    idle(40, 2);

    // Load and disarm together
    step(50, 1, 5, 0, 1, 0);
    idle(50, 3);

    // Fire counter saturation
    step(1000, 1, 0, 1, 0, 0);
    idle(1000, 300);
    step(1000, 0, 0, 0, 1, 1);

    // Alarm register wrap-around
    step(64'hFFFF_FFFF_FFFF_FFFF, 1, 64'hFFFF_FFFF_FFFF_FFFE, 5, 0, 0);
    idle(64'hFFFF_FFFF_FFFF_FFFF, 3);
    idle(2, 3);
    step(9, 0, 0, 0, 1, 1);

    // Randomized traffic
    t = 64'd200;
    for (int k = 0; k < 500; k++) begin
      bit          ld, dis, ak;
      logic [63:0] al;
      logic [31:0] per;
      case ($urandom_range(0, 19))
        0:       t = t + 64'($urandom_range(20, 60));
        1:       t = t - 64'($urandom_range(0, 30));
        default: t = t + 64'($urandom_range(0, 3));
      endcase
      ld  = !m_armed && ($urandom_range(0, 5) == 0);
      al  = t + 64'($urandom_range(0, 25)) - 64'd5;
      per = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 8));
      dis = ($urandom_range(0, 39) == 0);
      ak  = ($urandom_range(0, 9) == 0);
      step(t, ld, al, per, dis, ak);
    end

    // Async reset mid-pulse while armed
    step(t, 0, 0, 0, 1, 1);
    step(9, 1, 10, 1000, 0, 0);
    step(10, 0, 0, 0, 0, 0);
    idle(10, 6);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_zero("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle(5000, 5);

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
